// File: rtl/floo_rsp_meta_table.sv
// Responder-side metadata table: parks NoC request metadata in a slot whose index
// becomes the subordinate AXI ID, then reattaches it to the matching response.
module floo_rsp_meta_table #(
   parameter int unsigned MaxTxns   = 8,
   parameter type         meta_t    = logic,
   parameter type         slot_id_t = logic [$clog2(MaxTxns)-1:0]
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [$bits(meta_t)-1:0]     req_meta_i,
   output logic                         req_valid_o,
   input  logic                         req_ready_i,
   output logic [$bits(slot_id_t)-1:0]  req_id_o,
   input  logic                         rsp_valid_i,
   output logic                         rsp_ready_o,
   input  logic [$bits(slot_id_t)-1:0]  rsp_id_i,
   input  logic                         rsp_last_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [$bits(meta_t)-1:0]     rsp_meta_o,
   output logic                         full_o,
   output logic [$clog2(MaxTxns):0]     inflight_o,
   output logic                         err_o
);

   localparam int unsigned IdxW  = $clog2(MaxTxns);
   localparam int unsigned IdW   = $bits(slot_id_t);
   localparam int unsigned CntW  = IdxW + 1;
   localparam int unsigned MetaW = $bits(meta_t);

   logic [MaxTxns-1:0] vld_q, vld_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               lock_q, lock_d;
   logic [IdxW-1:0]    lock_idx_q, lock_idx_d;
   logic               err_q, err_d;
   logic [MetaW-1:0]   meta_q [MaxTxns];

   logic [IdxW-1:0]    free_idx, alloc_idx, rsp_idx;
   logic               alloc, release_slot, rsp_in_range, rsp_legal;

   // Lowest free slot, taken from the registered vector only (no same-cycle reuse).
   always_comb begin
      free_idx = '0;
      for (int i = int'(MaxTxns) - 1; i >= 0; i--) begin
         if (!vld_q[i]) free_idx = IdxW'(i);
      end
   end

   assign full_o      = &vld_q;
   assign req_valid_o = req_valid_i & ~full_o;
   assign req_ready_o = req_ready_i & ~full_o;
   assign alloc_idx   = lock_q ? lock_idx_q : free_idx;
   assign req_id_o    = IdW'(alloc_idx);
   assign alloc       = req_valid_i & req_ready_o;

   assign rsp_in_range = 32'(rsp_id_i) < MaxTxns;
   assign rsp_idx      = IdxW'(rsp_id_i);
   assign rsp_legal    = rsp_in_range && vld_q[rsp_idx];
   assign rsp_valid_o  = rsp_valid_i & rsp_legal;
   // An illegal beat is swallowed so a stray ID cannot wedge the subordinate.
   assign rsp_ready_o  = rsp_legal ? rsp_ready_i : 1'b1;
   assign rsp_meta_o   = rsp_in_range ? meta_q[rsp_idx] : '0;
   assign release_slot = rsp_valid_i & rsp_ready_i & rsp_legal & rsp_last_i;

   assign inflight_o = count_q;
   assign err_o      = err_q;

   // NOTE: combinational blocks use blocking '=' with every output defaulted first,
   // which keeps them free of latches; the registers below use '<=' only.
   always_comb begin
      vld_d      = vld_q;
      count_d    = count_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      err_d      = err_q | (rsp_valid_i & ~rsp_legal);
      if (alloc)        vld_d[alloc_idx] = 1'b1;
      if (release_slot) vld_d[rsp_idx]   = 1'b0;
      case ({alloc, release_slot})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (req_valid_o && !req_ready_i) begin
         lock_d     = 1'b1;
         lock_idx_d = alloc_idx;
      end else if (alloc) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q   <= '0;
         count_q <= '0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   // NOTE: payload storage carries no reset; its contents only matter where vld_q
   // or lock_q marks them valid, and those flags are reset.
   always_ff @(posedge clk_i) begin
      lock_idx_q <= lock_idx_d;
      if (alloc) meta_q[alloc_idx] <= req_meta_i;
   end

   a_no_double_alloc: assert property (@(posedge clk_i) disable iff (rst_i)
      alloc |-> !vld_q[alloc_idx]);
   a_count_matches: assert property (@(posedge clk_i) disable iff (rst_i)
      int'(count_q) == $countones(vld_q));
   a_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_o && !req_ready_i) |=> (req_id_o == $past(req_id_o)));

endmodule
